// File: rtl/lab02_pkg.sv
// lab02_pkg -- shared definitions for the lab02 sequence checker.
//   state_t     : checker FSM state encoding (IDLE, TRACK, DONE)
//   NO_ERR_IDX  : first_err_idx value meaning "no failing triple yet"
//   CNT_MAX     : saturation value of the 16-bit result counters
package lab02_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/lab02_sat_cnt.sv
// lab02_sat_cnt -- 16-bit up counter that sticks at CNT_MAX.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   clear : synchronous restart (count -> 0), dominates inc
//   inc   : add one this cycle unless already saturated
//   count : current value
module lab02_sat_cnt
  import lab02_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/lab02_seq_checker.sv
// lab02_seq_checker -- checks a stream of (a, b, sum) triples from a
// Fibonacci-style generator: every sum must equal a + b (carry dropped)
// and every triple after the first must continue the previous one
// (a == prev_b, b == prev_sum). Counts passes/failures and records the
// index of the first failure of a run.
//   clk, rst        : clock / asynchronous active-high reset
//   clear           : synchronous restart, beats a same-cycle handshake
//   in_valid, a, b, sum : triple input, taken when in_valid && in_ready
//   in_ready        : high in IDLE and TRACK, low in DONE
//   pass_cnt, err_cnt : saturating result counters
//   first_err_idx   : 0-based index of first failing triple, FFFF if none
//   done, timeout   : run finished / finished through inactivity
// All outputs are registered.
module lab02_seq_checker
  import lab02_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int EXP_LEN = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             in_ready,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_err_idx,
  output logic             done,
  output logic             timeout
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  // idx holds the number of triples already taken, so the handshake that
  // sees idx == LAST_IDX is the one that completes the run.
  localparam logic [15:0] LAST_IDX = 16'(EXP_LEN - 1);

  state_t            state;
  logic [WIDTH-1:0]  prev_b;
  logic [WIDTH-1:0]  prev_sum;
  logic [15:0]       idx;
  logic [IDLE_W-1:0] idle_cnt;

  logic [WIDTH-1:0]  sum_exp;
  logic              check_a;
  logic              check_b;
  logic              triple_ok;
  logic              hs;

  // Width-limited add discards the carry, giving the mod 2^WIDTH result.
  assign sum_exp   = a + b;
  assign check_a   = (sum == sum_exp);
  // The first triple of a run has no predecessor; only TRACK chains.
  assign check_b   = (state == ST_TRACK) ? ((a == prev_b) && (b == prev_sum)) : 1'b1;
  assign triple_ok = check_a && check_b;
  // A triple arriving with clear is thrown away.
  assign hs        = in_valid && in_ready && !clear;

  lab02_sat_cnt u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (hs && triple_ok),
    .count (pass_cnt)
  );

  lab02_sat_cnt u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (hs && !triple_ok),
    .count (err_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      done          <= 1'b0;
      timeout       <= 1'b0;
      prev_b        <= '0;
      prev_sum      <= '0;
      idx           <= '0;
      idle_cnt      <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (clear) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      done          <= 1'b0;
      timeout       <= 1'b0;
      prev_b        <= '0;
      prev_sum      <= '0;
      idx           <= '0;
      idle_cnt      <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else begin
      case (state)
        ST_IDLE, ST_TRACK: begin
          if (hs) begin
            // Failing triples still become the reference for the next one.
            prev_b   <= b;
            prev_sum <= sum;
            idx      <= idx + 16'd1;
            idle_cnt <= '0;
            if (!triple_ok && (first_err_idx == NO_ERR_IDX)) begin
              first_err_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ST_TRACK;
            end
          end else if (state == ST_TRACK) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              timeout  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Parked until clear or rst.
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab02_seq_checker.sv
module tb_lab02_seq_checker;

  localparam int WIDTH   = 32;
  localparam int EXP_LEN = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             in_ready;
  logic [15:0]      pass_cnt;
  logic [15:0]      err_cnt;
  logic [15:0]      first_err_idx;
  logic             done;
  logic             timeout;

  lab02_seq_checker #(
    .WIDTH   (WIDTH),
    .EXP_LEN (EXP_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .sum           (sum),
    .in_ready      (in_ready),
    .pass_cnt      (pass_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .done          (done),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The run is the list of accepted triples; everything else follows
  // from the rules applied to that list.
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } trip_t;

  trip_t run_q[$];
  int    m_pass, m_err, m_first, m_idle;
  bit    m_done, m_to;

  function automatic void model_reset();
    run_q.delete();
    m_pass  = 0;
    m_err   = 0;
    m_first = -1;
    m_idle  = 0;
    m_done  = 0;
    m_to    = 0;
  endfunction

  initial begin
    bit               ok;
    logic [WIDTH-1:0] s_exp;
    trip_t            t;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst || clear) begin
        model_reset();
      end else if (!m_done) begin
        if (in_valid) begin
          s_exp = a + b;
          ok = (sum == s_exp);
          if (run_q.size() > 0)
            ok = ok && (a == run_q[$].b) && (b == run_q[$].s);
          if (ok) begin
            if (m_pass < 65535) m_pass++;
          end else begin
            if (m_err < 65535) m_err++;
            if (m_first < 0) m_first = run_q.size();
          end
          t.a = a; t.b = b; t.s = sum;
          run_q.push_back(t);
          m_idle = 0;
          if (run_q.size() == EXP_LEN) m_done = 1;
        end else if (run_q.size() > 0) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_done = 1;
            m_to   = 1;
          end
        end
      end
    end
  end

  // Per-cycle compare, 1 time unit after the rising edge.
  bit cmp_en = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        check("in_ready", in_ready, !m_done);
        check("pass_cnt", pass_cnt, m_pass);
        check("err_cnt", err_cnt, m_err);
        check("first_err_idx", first_err_idx, (m_first < 0) ? 32'hFFFF : m_first);
        check("done", done, m_done);
        check("timeout", timeout, m_to);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic [WIDTH-1:0] ts);
    a = ta; b = tb; sum = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends n Fibonacci triples starting at (1,1,2); the triple at bad_idx
  // carries sum+1, later triples keep the true sequence.
  task automatic run_fib(input int n, input int bad_idx);
    logic [WIDTH-1:0] x, y, s;
    x = 1; y = 1;
    for (int i = 0; i < n; i++) begin
      s = x + y;
      send(x, y, (i == bad_idx) ? s + 1 : s);
      x = y; y = s;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; sum = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst pass_cnt", pass_cnt, 0);
    check("rst first_err_idx", first_err_idx, 32'hFFFF);
    rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);

    // Clean 16-triple Fibonacci run; last is (987,1597,2584).
    run_fib(16, -1);
    $display("fib run: pass=%0d err=%0d first=%0h done=%0b", pass_cnt, err_cnt, first_err_idx, done);
    check("fib pass_cnt", pass_cnt, 16);
    check("fib err_cnt", err_cnt, 0);
    check("fib first_err_idx", first_err_idx, 32'hFFFF);
    check("fib done", done, 1);
    check("fib in_ready", in_ready, 0);
    // DONE ignores further triples.
    send(1, 1, 2);
    check("done ignores pass_cnt", pass_cnt, 16);
    pulse_clear();
    check("clear pass_cnt", pass_cnt, 0);
    check("clear done", done, 0);

    // Fifth triple (5,8,13) sent as (5,8,14): 0-based index 4 fails
    // check A, the next one (8,13,21) then fails check B.
    run_fib(16, 4);
    $display("bad-sum run: pass=%0d err=%0d first=%0h", pass_cnt, err_cnt, first_err_idx);
    check("bad err_cnt", err_cnt, 2);
    check("bad pass_cnt", pass_cnt, 14);
    check("bad first_err_idx", first_err_idx, 4);
    pulse_clear();

    // Carry is discarded.
    send(32'hFFFF_FFFF, 2, 1);
    $display("wrap triple: pass=%0d err=%0d", pass_cnt, err_cnt);
    check("wrap pass_cnt", pass_cnt, 1);
    check("wrap err_cnt", err_cnt, 0);
    pulse_clear();

    // Inactivity: one cycle short of the limit, then the limit.
    run_fib(3, -1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("idle-63 done", done, 0);
    @(negedge clk);
    $display("timeout run: pass=%0d done=%0b timeout=%0b", pass_cnt, done, timeout);
    check("timeout done", done, 1);
    check("timeout flag", timeout, 1);
    check("timeout pass_cnt", pass_cnt, 3);
    pulse_clear();

    // Async rst in mid-run, then a fresh full run.
    run_fib(7, -1);
    rst = 1'b1;
    #1;
    check("async rst pass_cnt", pass_cnt, 0);
    check("async rst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after rst first_err_idx", first_err_idx, 32'hFFFF);
    run_fib(16, -1);
    $display("post-rst run: pass=%0d done=%0b", pass_cnt, done);
    check("post-rst run pass_cnt", pass_cnt, 16);
    check("post-rst run done", done, 1);
    pulse_clear();

    // clear together with the 4th triple: triple dropped, back to IDLE.
    run_fib(3, -1);
    a = 3; b = 5; sum = 8; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    $display("clear+valid: pass=%0d err=%0d ready=%0b", pass_cnt, err_cnt, in_ready);
    check("clr+hs pass_cnt", pass_cnt, 0);
    check("clr+hs err_cnt", err_cnt, 0);
    check("clr+hs in_ready", in_ready, 1);
    // Next triple is treated as a first triple (check A only).
    send(3, 5, 8);
    send(5, 8, 13);
    check("restart pass_cnt", pass_cnt, 2);

    @(negedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
